// File: rtl/drive_trip_supervisor_if.sv
// Status inputs and actuator outputs of drive_trip_supervisor, bundled as one interface.
// The master modport is the status source; the slave modport is the supervisor itself.
interface drive_trip_supervisor_if;
    logic       start;
    logic       arrived;
    logic       gas_tank_empty;
    logic       cpu_overheated;
    logic       keep_driving;
    logic       shut_off_computer;
    logic       refueling;
    logic       trip_done;
    logic [1:0] state;

    modport master (
        output start, arrived, gas_tank_empty, cpu_overheated,
        input  keep_driving, shut_off_computer, refueling, trip_done, state
    );

    modport slave (
        input  start, arrived, gas_tank_empty, cpu_overheated,
        output keep_driving, shut_off_computer, refueling, trip_done, state
    );
endinterface

// File: rtl/drive_trip_supervisor.sv
// Trip FSM (IDLE/DRIVE/REFUEL/DONE) with a timed refuel stop and a registered thermal shutdown.
// Define DRIVE_SUP_THERMAL_HOLD_EN to keep shut_off_computer high COOL_CYCLES extra cycles.
module drive_trip_supervisor #(
    parameter int REFUEL_CYCLES = 8,
    parameter int COOL_CYCLES   = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    drive_trip_supervisor_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        REFUEL = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int RCW = (REFUEL_CYCLES > 1) ? $clog2(REFUEL_CYCLES) : 1;
    localparam logic [RCW-1:0] REFUEL_LOAD = RCW'(REFUEL_CYCLES - 1);

    if (REFUEL_CYCLES < 1 || COOL_CYCLES < 1) begin : g_bad_params
        $error("drive_trip_supervisor: REFUEL_CYCLES and COOL_CYCLES must be >= 1");
    end

    state_t         state_q;
    logic [RCW-1:0] refuel_cnt_q;
    logic           shut_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            refuel_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) state_q <= DRIVE;
                end
                DRIVE: begin
                    // arrival beats an empty tank when both are seen together
                    if (bus.arrived) begin
                        state_q <= DONE;
                    end else if (bus.gas_tank_empty) begin
                        state_q      <= REFUEL;
                        refuel_cnt_q <= REFUEL_LOAD;
                    end
                end
                REFUEL: begin
                    if (refuel_cnt_q != '0) begin
                        refuel_cnt_q <= refuel_cnt_q - 1'b1;
                    end else if (bus.gas_tank_empty) begin
                        refuel_cnt_q <= REFUEL_LOAD;
                    end else begin
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    if (!bus.arrived) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DRIVE_SUP_THERMAL_HOLD_EN
    localparam int CCW = $clog2(COOL_CYCLES + 1);
    localparam logic [CCW-1:0] COOL_LOAD = CCW'(COOL_CYCLES);

    logic [CCW-1:0] cool_cnt_q;

    // Output stays set while the hold counter drains, then clears one cycle after it reaches 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shut_q     <= 1'b0;
            cool_cnt_q <= '0;
        end else if (bus.cpu_overheated) begin
            shut_q     <= 1'b1;
            cool_cnt_q <= COOL_LOAD;
        end else if (cool_cnt_q != '0) begin
            cool_cnt_q <= cool_cnt_q - 1'b1;
        end else begin
            shut_q <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shut_q <= 1'b0;
        end else begin
            shut_q <= bus.cpu_overheated;
        end
    end
`endif

    assign bus.keep_driving      = (state_q == DRIVE) && !shut_q;
    assign bus.shut_off_computer = shut_q;
    assign bus.refueling         = (state_q == REFUEL);
    assign bus.trip_done         = (state_q == DONE);
    assign bus.state             = state_q;
endmodule

// File: tb/tb_drive_trip_supervisor.sv
// Self-checking bench for drive_trip_supervisor: vector table plus hand-written refuel,
// thermal and mid-operation reset sequences, checked through an expected-value queue.
module tb_drive_trip_supervisor;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    drive_trip_supervisor_if bus ();

    drive_trip_supervisor #(
        .REFUEL_CYCLES (8),
        .COOL_CYCLES   (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifdef DRIVE_SUP_THERMAL_HOLD_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 0;
`endif

    // expected outputs packed as {state[1:0], keep_driving, shut_off_computer, refueling, trip_done}
    localparam logic [5:0] E_IDLE   = 6'b00_0000;
    localparam logic [5:0] E_DRIVE  = 6'b01_1000;
    localparam logic [5:0] E_DRSHUT = 6'b01_0100;
    localparam logic [5:0] E_REFUEL = 6'b10_0010;
    localparam logic [5:0] E_DONE   = 6'b11_0001;

    typedef struct packed {
        logic       rn;
        logic       st;
        logic       ar;
        logic       ge;
        logic       co;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl [12];
    logic [5:0] exp_q [$];
    int         total = 0;
    int         bad   = 0;

    // Drive one cycle of inputs, queue the expectation, then check just after the edge.
    task automatic step(input logic rn, input logic st, input logic ar, input logic ge,
                        input logic co, input logic [5:0] exp, input string name);
        logic [5:0] got;
        logic [5:0] want;
        @(negedge clk);
        resetn             = rn;
        bus.start          = st;
        bus.arrived        = ar;
        bus.gas_tank_empty = ge;
        bus.cpu_overheated = co;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got  = {bus.state, bus.keep_driving, bus.shut_off_computer, bus.refueling, bus.trip_done};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got {state,kd,shut,ref,done}=%b_%b%b%b%b required %b_%b%b%b%b",
                     name, got[5:4], got[3], got[2], got[1], got[0],
                     want[5:4], want[3], want[2], want[1], want[0]);
        end else begin
            $display("ok   %s: {state,kd,shut,ref,done}=%b_%b%b%b%b",
                     name, got[5:4], got[3], got[2], got[1], got[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start          = 1'b0;
        bus.arrived        = 1'b0;
        bus.gas_tank_empty = 1'b0;
        bus.cpu_overheated = 1'b0;

        //            rn    st    ar    ge    co    expected
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, E_IDLE};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, E_IDLE};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, E_IDLE};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_DRIVE};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_DRIVE};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_DONE};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_DONE};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_DRIVE};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_DONE};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_DRIVE};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rn, tbl[i].st, tbl[i].ar, tbl[i].ge, tbl[i].co, tbl[i].exp,
                 $sformatf("vec%0d", i));
        end

        // single-cycle empty-tank pulse: exactly 8 refuel cycles, then back to DRIVE
        step(1, 0, 0, 1, 0, E_REFUEL, "refuel_pulse_enter");
        for (int i = 1; i < 8; i++) step(1, 0, 1, 0, 0, E_REFUEL, $sformatf("refuel_pulse_c%0d", i));
        step(1, 0, 0, 0, 0, E_DRIVE, "refuel_pulse_exit");

        // tank held empty for three full stops, released at the last counter-zero cycle
        for (int i = 0; i < 24; i++) step(1, 0, 0, 1, 0, E_REFUEL, $sformatf("refuel_held_c%0d", i));
        step(1, 0, 0, 0, 0, E_DRIVE, "refuel_held_exit");

        // thermal pause: overheat for 2 cycles while driving
        step(1, 0, 0, 0, 1, E_DRSHUT, "thermal_c0");
        step(1, 0, 0, 0, 1, E_DRSHUT, "thermal_c1");
        for (int i = 2; i < 10; i++) begin
            step(1, 0, 0, 0, 0, (i < 2 + HOLD) ? E_DRSHUT : E_DRIVE, $sformatf("thermal_c%0d", i));
        end

        // reset while the refuel counter reads 3
        step(1, 0, 0, 1, 0, E_REFUEL, "rst_refuel_enter");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, E_REFUEL, $sformatf("rst_refuel_c%0d", i));
        step(0, 0, 0, 0, 0, E_IDLE, "rst_mid_refuel");

        // reset during a shutdown, overheat still asserted on the reset edge
        step(1, 1, 0, 0, 0, E_DRIVE, "rst_thermal_start");
        step(1, 0, 0, 0, 1, E_DRSHUT, "rst_thermal_shut");
        step(0, 0, 0, 0, 1, E_IDLE, "rst_mid_thermal");

        // fresh trip after restart: full-length refuel stop
        step(1, 1, 0, 0, 0, E_DRIVE, "restart_start");
        step(1, 0, 0, 1, 0, E_REFUEL, "restart_refuel_enter");
        for (int i = 1; i < 8; i++) step(1, 0, 0, 0, 0, E_REFUEL, $sformatf("restart_refuel_c%0d", i));
        step(1, 0, 0, 0, 0, E_DRIVE, "restart_refuel_exit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
